// File: rtl/matvec_scheduler.sv
// Matrix-vector issue scheduler: streams A coefficients to the MV core row by row,
// tracks returned results, and signals row / operation completion.
module matvec_scheduler #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_k_param,
  input  logic [3:0]       i_l_param,
  input  logic             i_a_valid,
  input  logic [WIDTH-1:0] i_a_data,
  output logic             o_a_ready,
  output logic             o_core_valid,
  output logic [WIDTH-1:0] o_core_data,
  output logic [7:0]       o_core_m_idx,
  output logic [3:0]       o_core_j_idx,
  output logic [3:0]       o_core_l_param,
  input  logic             i_res_valid,
  input  logic [7:0]       i_res_m_idx,
  output logic             o_row_done,
  output logic [3:0]       o_row_idx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cfg_err,
  output logic             o_seq_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [3:0]       k_q, k_d, l_q, l_d, j_q, j_d, row_q, row_d;
  logic [7:0]       m_q, m_d;
  logic [8:0]       res_cnt_q, res_cnt_d;
  logic             cfg_err_q, cfg_err_d, seq_err_q, seq_err_d;
  logic             core_valid_q, core_valid_d;
  logic [WIDTH-1:0] core_data_q, core_data_d;
  logic [7:0]       core_m_q, core_m_d;
  logic [3:0]       core_j_q, core_j_d;

  logic accept, cfg_ok, row_end, last_row;

  assign accept   = (state_q == StRun) && i_a_valid;
  assign cfg_ok   = (i_k_param != 4'd0) && (i_k_param <= 4'd8) &&
                    (i_l_param != 4'd0) && (i_l_param <= 4'd7);
  // Row completes only once every result of the row has come back from the core.
  assign row_end  = (state_q == StDrain) && (res_cnt_q == 9'd256);
  assign last_row = (row_q == k_q - 4'd1);

  // Next-state logic for the FSM, index counters, result tracking and issue register.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    l_d          = l_q;
    j_d          = j_q;
    m_d          = m_q;
    row_d        = row_q;
    res_cnt_d    = res_cnt_q;
    cfg_err_d    = 1'b0;
    seq_err_d    = seq_err_q;
    core_valid_d = 1'b0;
    core_data_d  = core_data_q;
    core_m_d     = core_m_q;
    core_j_d     = core_j_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          if (cfg_ok) begin
            k_d       = i_k_param;
            l_d       = i_l_param;
            m_d       = 8'd0;
            j_d       = 4'd0;
            row_d     = 4'd0;
            res_cnt_d = 9'd0;
            seq_err_d = 1'b0;
            state_d   = StRun;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRun, StDrain: begin
        if (row_end) begin
          res_cnt_d = 9'd0;
          m_d       = 8'd0;
          j_d       = 4'd0;
          if (last_row) begin
            state_d = StIdle;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = StRun;
          end
        end else begin
          if (i_res_valid) begin
            res_cnt_d = res_cnt_q + 9'd1;
            if (i_res_m_idx != res_cnt_q[7:0]) seq_err_d = 1'b1;
          end
          if (accept) begin
            core_valid_d = 1'b1;
            core_data_d  = i_a_data;
            core_m_d     = m_q;
            core_j_d     = j_q;
            m_d          = m_q + 8'd1;
            if (m_q == 8'hff) begin
              j_d = j_q + 4'd1;
              // Last coefficient of the row issued: wait for the core to finish.
              if (j_q == l_q - 4'd1) state_d = StDrain;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous active-low reset clearing everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      k_q          <= 4'd0;
      l_q          <= 4'd0;
      j_q          <= 4'd0;
      m_q          <= 8'd0;
      row_q        <= 4'd0;
      res_cnt_q    <= 9'd0;
      cfg_err_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
      core_m_q     <= 8'd0;
      core_j_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      l_q          <= l_d;
      j_q          <= j_d;
      m_q          <= m_d;
      row_q        <= row_d;
      res_cnt_q    <= res_cnt_d;
      cfg_err_q    <= cfg_err_d;
      seq_err_q    <= seq_err_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      core_m_q     <= core_m_d;
      core_j_q     <= core_j_d;
    end
  end

  assign o_a_ready      = (state_q == StRun);
  assign o_busy         = (state_q != StIdle);
  assign o_core_valid   = core_valid_q;
  assign o_core_data    = core_data_q;
  assign o_core_m_idx   = core_m_q;
  assign o_core_j_idx   = core_j_q;
  assign o_core_l_param = l_q;
  assign o_row_done     = row_end;
  assign o_done         = row_end && last_row;
  assign o_row_idx      = row_q;
  assign o_cfg_err      = cfg_err_q;
  assign o_seq_err      = seq_err_q;

endmodule

// File: tb/tb_matvec_scheduler.sv
// Randomized bench for matvec_scheduler: a transaction-level model predicts every output,
// a 7-deep delay line stands in for the matrix-vector core.
module tb_matvec_scheduler;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [3:0]   i_k_param = 4'd0;
  logic [3:0]   i_l_param = 4'd0;
  logic         i_a_valid = 1'b0;
  logic [W-1:0] i_a_data = '0;
  logic         o_a_ready;
  logic         o_core_valid;
  logic [W-1:0] o_core_data;
  logic [7:0]   o_core_m_idx;
  logic [3:0]   o_core_j_idx;
  logic [3:0]   o_core_l_param;
  logic         i_res_valid = 1'b0;
  logic [7:0]   i_res_m_idx = 8'd0;
  logic         o_row_done;
  logic [3:0]   o_row_idx;
  logic         o_busy;
  logic         o_done;
  logic         o_cfg_err;
  logic         o_seq_err;

  matvec_scheduler #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_k_param     (i_k_param),
    .i_l_param     (i_l_param),
    .i_a_valid     (i_a_valid),
    .i_a_data      (i_a_data),
    .o_a_ready     (o_a_ready),
    .o_core_valid  (o_core_valid),
    .o_core_data   (o_core_data),
    .o_core_m_idx  (o_core_m_idx),
    .o_core_j_idx  (o_core_j_idx),
    .o_core_l_param(o_core_l_param),
    .i_res_valid   (i_res_valid),
    .i_res_m_idx   (i_res_m_idx),
    .o_row_done    (o_row_done),
    .o_row_idx     (o_row_idx),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_cfg_err     (o_cfg_err),
    .o_seq_err     (o_seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model state: an operation is a busy flag plus counts of beats issued and results seen
  // in the current row; everything else follows arithmetically from those counts.
  bit           m_busy = 1'b0;
  int           m_k = 0, m_l = 0, m_row = 0, m_issued = 0, m_res = 0;
  bit           m_seq_err = 1'b0, m_cfg_err = 1'b0, m_core_valid = 1'b0;
  logic [W-1:0] m_core_data = '0;
  int           m_core_m = 0, m_core_j = 0;

  function automatic bit cfg_ok(input int k, input int l);
    return (k >= 1) && (k <= 8) && (l >= 1) && (l <= 7);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_k <= 0; m_l <= 0; m_row <= 0; m_issued <= 0; m_res <= 0;
      m_seq_err <= 1'b0; m_cfg_err <= 1'b0; m_core_valid <= 1'b0; m_core_data <= '0;
      m_core_m <= 0; m_core_j <= 0;
    end else begin
      m_cfg_err    <= 1'b0;
      m_core_valid <= 1'b0;
      if (!m_busy) begin
        if (i_start) begin
          if (cfg_ok(int'(i_k_param), int'(i_l_param))) begin
            m_busy <= 1'b1; m_k <= int'(i_k_param); m_l <= int'(i_l_param);
            m_row <= 0; m_issued <= 0; m_res <= 0; m_seq_err <= 1'b0;
          end else begin
            m_cfg_err <= 1'b1;
          end
        end
      end else if (m_issued == 256 * m_l && m_res == 256) begin
        m_issued <= 0;
        m_res    <= 0;
        if (m_row == m_k - 1) m_busy <= 1'b0;
        else m_row <= m_row + 1;
      end else begin
        if (i_res_valid) begin
          if (int'(i_res_m_idx) != m_res % 256) m_seq_err <= 1'b1;
          m_res <= m_res + 1;
        end
        if (i_a_valid && m_issued < 256 * m_l) begin
          m_core_valid <= 1'b1;
          m_core_data  <= i_a_data;
          m_core_m     <= m_issued % 256;
          m_core_j     <= m_issued / 256;
          m_issued     <= m_issued + 1;
        end
      end
    end
  end

  // Core stand-in and observation counters.
  bit       pipe_v [7];
  bit [7:0] pipe_m [7];
  bit       inject_en = 1'b0;
  int       n_beats = 0, n_rowdone = 0, n_done = 0, n_cfg = 0;
  bit       exp_drain, exp_rd;

  always @(negedge clk) begin
    exp_drain = m_busy && (m_issued == 256 * m_l);
    exp_rd    = exp_drain && (m_res == 256);
    check("busy", 64'(o_busy), 64'(m_busy));
    check("a_ready", 64'(o_a_ready), 64'(m_busy && !exp_drain));
    check("core_valid", 64'(o_core_valid), 64'(m_core_valid));
    if (m_core_valid) begin
      check("core_data", 64'(o_core_data), 64'(m_core_data));
      check("core_m_idx", 64'(o_core_m_idx), 64'(m_core_m));
      check("core_j_idx", 64'(o_core_j_idx), 64'(m_core_j));
    end
    check("core_l_param", 64'(o_core_l_param), 64'(m_l));
    check("row_done", 64'(o_row_done), 64'(exp_rd));
    check("done", 64'(o_done), 64'(exp_rd && (m_row == m_k - 1)));
    check("row_idx", 64'(o_row_idx), 64'(m_row));
    check("cfg_err", 64'(o_cfg_err), 64'(m_cfg_err));
    check("seq_err", 64'(o_seq_err), 64'(m_seq_err));
    if (o_core_valid) n_beats++;
    if (o_row_done) n_rowdone++;
    if (o_cfg_err) n_cfg++;
    if (o_done) begin
      n_done++;
      check("done_with_row_done", 64'(o_row_done), 64'(1));
    end
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin pipe_v[i] = 1'b0; pipe_m[i] = 8'd0; end
      i_res_valid = 1'b0;
      i_res_m_idx = 8'd0;
    end else begin
      i_res_valid = pipe_v[6];
      i_res_m_idx = pipe_m[6];
      if (inject_en && pipe_v[6] && pipe_m[6] == 8'd3) begin
        i_res_m_idx = 8'd5;
        inject_en   = 1'b0;
      end
      for (int i = 6; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_m[i] = pipe_m[i-1]; end
      pipe_v[0] = o_core_valid && (int'(o_core_j_idx) == m_l - 1);
      pipe_m[0] = o_core_m_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_counts();
    n_beats = 0; n_rowdone = 0; n_done = 0; n_cfg = 0;
  endtask

  task automatic start(input int k, input int l);
    i_start   = 1'b1;
    i_k_param = 4'(k);
    i_l_param = 4'(l);
    i_a_valid = 1'b0;
    tick();
    i_start   = 1'b0;
  endtask

  task automatic run_to_idle(input int gap_pct, input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      i_a_valid = ($urandom_range(0, 99) >= gap_pct);
      i_a_data  = W'($urandom);
      tick();
      n++;
    end
    i_a_valid = 1'b0;
    check("run_to_idle_in_budget", 64'(n < budget), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(o_busy), 64'(0));
    check({tag, "_a_ready"}, 64'(o_a_ready), 64'(0));
    check({tag, "_core_valid"}, 64'(o_core_valid), 64'(0));
    check({tag, "_core_data"}, 64'(o_core_data), 64'(0));
    check({tag, "_core_m"}, 64'(o_core_m_idx), 64'(0));
    check({tag, "_core_j"}, 64'(o_core_j_idx), 64'(0));
    check({tag, "_core_l"}, 64'(o_core_l_param), 64'(0));
    check({tag, "_row_done"}, 64'(o_row_done), 64'(0));
    check({tag, "_row_idx"}, 64'(o_row_idx), 64'(0));
    check({tag, "_done"}, 64'(o_done), 64'(0));
    check({tag, "_cfg_err"}, 64'(o_cfg_err), 64'(0));
    check({tag, "_seq_err"}, 64'(o_seq_err), 64'(0));
  endtask

  initial begin
    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // k=1, l=1, continuous stream: one beat per cycle, one row, done with row_done.
    clr_counts();
    start(1, 1);
    for (int i = 0; i < 256; i++) begin
      i_a_valid = 1'b1;
      i_a_data  = W'($urandom);
      tick();
    end
    i_a_valid = 1'b0;
    @(negedge clk);
    #1;
    check("t1_throughput_beats", 64'(n_beats), 64'(256));
    check("t1_ready_low_in_drain", 64'(o_a_ready), 64'(0));
    run_to_idle(0, 100);
    check("t1_beats", 64'(n_beats), 64'(256));
    check("t1_row_done", 64'(n_rowdone), 64'(1));
    check("t1_done", 64'(n_done), 64'(1));
    check("t1_busy_after", 64'(o_busy), 64'(0));

    // k=2, l=4 with random gaps on the A stream.
    clr_counts();
    start(2, 4);
    run_to_idle(30, 6000);
    check("t2_beats", 64'(n_beats), 64'(2048));
    check("t2_row_done", 64'(n_rowdone), 64'(2));
    check("t2_done", 64'(n_done), 64'(1));
    check("t2_last_row", 64'(o_row_idx), 64'(1));

    // Bad configurations: one cfg_err pulse each, nothing starts.
    clr_counts();
    start(0, 1);
    tick();
    check("t3_busy_k0", 64'(o_busy), 64'(0));
    start(1, 9);
    tick();
    check("t3_busy_l9", 64'(o_busy), 64'(0));
    repeat (3) tick();
    check("t3_cfg_pulses", 64'(n_cfg), 64'(2));
    check("t3_beats", 64'(n_beats), 64'(0));

    // Result index 5 where 3 is due: sticky seq_err until the next good start.
    clr_counts();
    inject_en = 1'b1;
    start(1, 1);
    for (int i = 0; i < 30; i++) begin
      i_a_valid = 1'b1;
      i_a_data  = W'($urandom);
      tick();
    end
    check("t4_seq_err_set", 64'(o_seq_err), 64'(1));
    run_to_idle(10, 1000);
    check("t4_seq_err_held", 64'(o_seq_err), 64'(1));
    start(1, 1);
    tick();
    check("t4_seq_err_cleared", 64'(o_seq_err), 64'(0));
    run_to_idle(10, 1000);

    // Reset mid-run at m=100, j=2.
    clr_counts();
    start(2, 4);
    while (m_issued < 612 && n_beats < 2000) begin
      i_a_valid = 1'b1;
      i_a_data  = W'($urandom);
      tick();
    end
    i_a_valid = 1'b0;
    check("t5_reached_point", 64'(m_issued), 64'(612));
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    clr_counts();
    for (int i = 0; i < 30; i++) begin
      i_a_valid = 1'b1;
      tick();
    end
    i_a_valid = 1'b0;
    check("t5_no_beats", 64'(n_beats), 64'(0));
    check("t5_no_row_done", 64'(n_rowdone), 64'(0));
    check("t5_no_done", 64'(n_done), 64'(0));
    check("t5_idle", 64'(o_busy), 64'(0));
    start(1, 2);
    run_to_idle(20, 2000);
    check("t5_fresh_beats", 64'(n_beats), 64'(512));
    check("t5_fresh_row_done", 64'(n_rowdone), 64'(1));

    // Start pulsed during RUN is ignored.
    clr_counts();
    start(1, 3);
    for (int i = 0; i < 100; i++) begin
      i_a_valid = ($urandom_range(0, 99) >= 20);
      i_a_data  = W'($urandom);
      tick();
    end
    i_start   = 1'b1;
    i_k_param = 4'd5;
    i_l_param = 4'd1;
    tick();
    i_start   = 1'b0;
    check("t6_l_kept", 64'(o_core_l_param), 64'(3));
    check("t6_still_busy", 64'(o_busy), 64'(1));
    run_to_idle(20, 3000);
    check("t6_beats", 64'(n_beats), 64'(768));
    check("t6_row_done", 64'(n_rowdone), 64'(1));
    check("t6_done", 64'(n_done), 64'(1));

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
